// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if
//   Pin bundle between a serial-flash responder and its surroundings:
//   the four SPI wires plus the byte-wide read port into backing memory.
//   Parameters: ADDR_W - read address width.
//   Signals   : spi_cs, spi_sck, spi_mosi (initiator -> responder),
//               spi_miso (responder -> initiator),
//               mem_rd, mem_addr (responder -> memory),
//               mem_data (memory -> responder, one clk after mem_rd).
//   Modports  : slave  - the flash responder side,
//               master - the initiator/memory environment side.
`timescale 1ns/1ps
interface spi_flash_responder_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              spi_cs;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport slave (
        input  spi_cs, spi_sck, spi_mosi, mem_data,
        output spi_miso, mem_rd, mem_addr
    );

    modport master (
        output spi_cs, spi_sck, spi_mosi, mem_data,
        input  spi_miso, mem_rd, mem_addr
    );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 responder emulating a small serial NOR flash command set:
//   0x9F JEDEC ID, 0x05 status, 0x06/0x04 write-enable set/clear,
//   0xB9/0xAB deep power-down enter/release, 0x03 sequential read.
//   SPI pins are oversampled in clk (which must run at least 8x SCK).
//   Ports:
//     clk          - system clock
//     reset_n      - asynchronous active-low reset
//     bus          - slave modport: SPI pins and the memory read port
//     wel          - write-enable latch
//     powered_down - deep power-down state
`timescale 1ns/1ps
module spi_flash_responder #(
    parameter int unsigned ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_flash_responder_if.slave  bus,
    output logic                  wel,
    output logic                  powered_down
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        SRC_JEDEC,
        SRC_STATUS,
        SRC_READ
    } src_t;

    typedef enum logic [2:0] {
        PEND_NONE,
        PEND_WREN,
        PEND_WRDI,
        PEND_PD,
        PEND_REL
    } pend_t;

    localparam logic [5:0]        ADDR_LAST = 6'(ADDR_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Input conditioning
    logic [1:0] cs_sync;
    logic [1:0] sck_sync;
    logic [1:0] mosi_sync;
    logic       cs_prev;
    logic       sck_prev;
    logic       cs_lvl;
    logic       cs_rise;
    logic       sck_rise;
    logic       sck_fall;
    logic       mosi_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b1;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], bus.spi_cs};
            sck_sync  <= {sck_sync[0], bus.spi_sck};
            mosi_sync <= {mosi_sync[0], bus.spi_mosi};
            cs_prev   <= cs_sync[1];
            sck_prev  <= sck_sync[1];
        end
    end

    assign cs_lvl   = cs_sync[1];
    assign cs_rise  = cs_sync[1] & ~cs_prev;
    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sck_fall = ~sck_sync[1] & sck_prev;
    assign mosi_bit = mosi_sync[1];

    // Datapath registers
    state_t            state;
    state_t            state_next;
    logic [5:0]        bit_cnt;
    logic [6:0]        cmd_sr;
    logic [ADDR_W-1:0] addr;
    src_t              src;
    pend_t             pend;
    logic              extra_bit;
    logic [1:0]        jedec_idx;
    logic [7:0]        tx_sh;
    logic              miso_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              rd_pending;
    logic              wel_q;
    logic              pd_q;
    logic [7:0]        status_byte;

    assign status_byte = {6'b0, wel_q, 1'b0};

    // Opcode decode, evaluated on the 8th command rise
    logic [7:0] opcode;
    state_t     dec_state;
    src_t       dec_src;
    pend_t      dec_pend;

    always_comb begin
        opcode    = {cmd_sr, mosi_bit};
        dec_state = ST_IGNORE;
        dec_src   = SRC_JEDEC;
        dec_pend  = PEND_NONE;
        if (pd_q) begin
            // Only release is honoured while powered down.
            if (opcode == 8'hAB) begin
                dec_pend = PEND_REL;
            end
        end else begin
            case (opcode)
                8'h9F: begin
                    dec_state = ST_DATA;
                    dec_src   = SRC_JEDEC;
                end
                8'h05: begin
                    dec_state = ST_DATA;
                    dec_src   = SRC_STATUS;
                end
                8'h03: begin
                    dec_state = ST_ADDR;
                    dec_src   = SRC_READ;
                end
                8'h06:   dec_pend = PEND_WREN;
                8'h04:   dec_pend = PEND_WRDI;
                8'hB9:   dec_pend = PEND_PD;
                8'hAB:   dec_pend = PEND_REL;
                default: dec_pend = PEND_NONE;
            endcase
        end
    end

    // FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = ST_CMD;
            ST_CMD: begin
                if (sck_rise && bit_cnt == 6'd7) begin
                    state_next = dec_state;
                end
            end
            ST_ADDR: begin
                if (sck_rise && bit_cnt == ADDR_LAST) begin
                    state_next = ST_DATA;
                end
            end
            default: state_next = state;
        endcase
        if (cs_lvl) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            addr       <= '0;
            src        <= SRC_JEDEC;
            pend       <= PEND_NONE;
            extra_bit  <= 1'b0;
            jedec_idx  <= '0;
            tx_sh      <= '0;
            miso_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rd_pending <= 1'b0;
            wel_q      <= 1'b0;
            pd_q       <= 1'b0;
        end else begin
            mem_rd_q   <= 1'b0;
            rd_pending <= mem_rd_q;

            // Single-byte commands take effect only when cs rises with
            // no bit clocked after the opcode.
            if (cs_rise && state == ST_IGNORE && !extra_bit) begin
                case (pend)
                    PEND_WREN: wel_q <= 1'b1;
                    PEND_WRDI: wel_q <= 1'b0;
                    PEND_PD:   pd_q  <= 1'b1;
                    PEND_REL:  pd_q  <= 1'b0;
                    default:   ;
                endcase
            end

            if (cs_lvl) begin
                bit_cnt   <= '0;
                extra_bit <= 1'b0;
            end else if (sck_rise) begin
                case (state)
                    ST_CMD: begin
                        cmd_sr <= {cmd_sr[5:0], mosi_bit};
                        if (bit_cnt == 6'd7) begin
                            bit_cnt   <= '0;
                            src       <= dec_src;
                            pend      <= dec_pend;
                            jedec_idx <= 2'd0;
                            tx_sh     <= (dec_src == SRC_STATUS) ? status_byte
                                                                 : JEDEC_ID[23:16];
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    ST_ADDR: begin
                        addr <= {addr[ADDR_W-2:0], mosi_bit};
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt    <= '0;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= {addr[ADDR_W-2:0], mosi_bit};
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_cnt == 6'd7) begin
                            bit_cnt <= '0;
                            case (src)
                                SRC_JEDEC: begin
                                    if (jedec_idx != 2'd3) begin
                                        jedec_idx <= jedec_idx + 2'd1;
                                    end
                                    case (jedec_idx)
                                        2'd0:    tx_sh <= JEDEC_ID[15:8];
                                        2'd1:    tx_sh <= JEDEC_ID[7:0];
                                        default: tx_sh <= 8'h00;
                                    endcase
                                end
                                SRC_STATUS: tx_sh <= status_byte;
                                default: begin
                                    addr       <= addr + ADDR_ONE;
                                    mem_rd_q   <= 1'b1;
                                    mem_addr_q <= addr + ADDR_ONE;
                                end
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    ST_IGNORE: extra_bit <= 1'b1;
                    default:   ;
                endcase
            end

            if (state != ST_DATA) begin
                miso_q <= 1'b0;
            end else if (sck_fall) begin
                miso_q <= tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
            end

            // Read data lands two clk after the strobe's rise detect,
            // well ahead of the fall that presents its MSB.
            if (rd_pending) begin
                tx_sh <= bus.mem_data;
            end
        end
    end

    assign bus.spi_miso = miso_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign wel          = wel_q;
    assign powered_down = pd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder
//   Drives SPI transactions into spi_flash_responder, models the flash
//   command set at transaction level, and checks MISO bytes, memory read
//   strobes and the wel/powered_down flags through scoreboard queues.
`timescale 1ns/1ps
module tb_spi_flash_responder;
    localparam int unsigned ADDR_W = 24;
    localparam logic [23:0] JEDEC  = 24'hEF4016;

    logic clk = 1'b0;
    logic reset_n;
    logic wel;
    logic powered_down;

    spi_flash_responder_if #(.ADDR_W(ADDR_W)) bus ();

    spi_flash_responder #(
        .ADDR_W  (ADDR_W),
        .JEDEC_ID(JEDEC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .wel         (wel),
        .powered_down(powered_down)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp_miso[$];
    logic [23:0] exp_addr[$];
    logic [1:0]  exp_flags[$];
    bit          mon_en = 1'b0;
    bit          wel_m  = 1'b0;
    bit          pd_m   = 1'b0;

    function automatic logic [7:0] mem_f(input logic [23:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: one-cycle read latency.
    always @(posedge clk) begin
        bus.mem_data <= bus.mem_rd ? mem_f(bus.mem_addr) : 8'h00;
    end

    // MISO byte monitor: sampled on the initiator's sck rise.
    initial begin : mon_miso
        int         nb;
        logic [7:0] sh;
        nb = 0;
        sh = '0;
        wait (mon_en);
        forever begin
            @(posedge bus.spi_sck or posedge bus.spi_cs);
            if (bus.spi_cs) begin
                nb = 0;
            end else begin
                sh = {sh[6:0], bus.spi_miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_miso.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL miso_byte: got 0x%02h, expected no byte", sh);
                    end else begin
                        check("miso_byte", 32'(sh), 32'(exp_miso.pop_front()));
                    end
                end
            end
        end
    end

    // Read-strobe monitor: every high clk must match one expected address.
    initial begin : mon_rd
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (bus.mem_rd === 1'b1) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mem_rd: got strobe at 0x%06h, expected none", bus.mem_addr);
                end else begin
                    check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
                end
            end
        end
    end

    // Flag monitor: wel/powered_down settle a few clk after cs rises.
    initial begin : mon_flags
        logic [1:0] e;
        wait (mon_en);
        forever begin
            @(posedge bus.spi_cs);
            repeat (5) @(negedge clk);
            if (exp_flags.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL flags: got cs rise, expected none");
            end else begin
                e = exp_flags.pop_front();
                check("wel", 32'(wel), 32'(e[1]));
                check("powered_down", 32'(powered_down), 32'(e[0]));
            end
        end
    end

    initial begin : watchdog
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cs_low();
        @(negedge clk);
        bus.spi_cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // One bit at exactly 8 clk per sck period.
    task automatic sck_bit(input logic b);
        bus.spi_mosi = b;
        repeat (4) @(negedge clk);
        bus.spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        bus.spi_sck = 1'b0;
    endtask

    // Opcode followed by nbits further bits (address bits first for reads).
    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int unsigned nbits);
        logic [7:0]  eff;
        logic [23:0] jid;
        int unsigned nbytes;
        int unsigned ndata;
        jid    = JEDEC;
        eff    = (pd_m && op != 8'hAB) ? 8'h00 : op;
        nbytes = nbits / 8;
        exp_miso.push_back(8'h00);
        case (eff)
            8'h9F: begin
                for (int i = 0; i < int'(nbytes); i++) begin
                    exp_miso.push_back(i < 3 ? jid[23 - 8*i -: 8] : 8'h00);
                end
            end
            8'h05: begin
                for (int i = 0; i < int'(nbytes); i++) begin
                    exp_miso.push_back({6'b0, wel_m, 1'b0});
                end
            end
            8'h03: begin
                for (int i = 0; i < int'(nbytes) && i < 3; i++) begin
                    exp_miso.push_back(8'h00);
                end
                if (nbits >= 24) begin
                    ndata = (nbits - 24) / 8;
                    exp_addr.push_back(addr);
                    for (int i = 0; i < int'(ndata); i++) begin
                        exp_miso.push_back(mem_f(addr + 24'(i)));
                        exp_addr.push_back(addr + 24'(i + 1));
                    end
                end
            end
            default: begin
                for (int i = 0; i < int'(nbytes); i++) begin
                    exp_miso.push_back(8'h00);
                end
                if (nbits == 0) begin
                    case (eff)
                        8'h06:   wel_m = 1'b1;
                        8'h04:   wel_m = 1'b0;
                        8'hB9:   pd_m  = 1'b1;
                        8'hAB:   pd_m  = 1'b0;
                        default: ;
                    endcase
                end
            end
        endcase
        cs_low();
        for (int i = 7; i >= 0; i--) begin
            sck_bit(op[i]);
        end
        for (int unsigned i = 0; i < nbits; i++) begin
            sck_bit(i < 24 ? addr[23 - i] : 1'($urandom));
        end
        exp_flags.push_back({wel_m, pd_m});
        cs_high();
    endtask

    initial begin : driver
        bus.spi_cs   = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        reset_n      = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso", 32'(bus.spi_miso), 32'd0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wel", 32'(wel), 32'd0);
        check("rst_powered_down", 32'(powered_down), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        // Directed cases
        run_txn(8'h9F, 24'h0, 32);
        run_txn(8'h03, 24'h0001FE, 48);
        run_txn(8'h03, 24'hFFFFFF, 40);
        run_txn(8'h06, 24'h0, 0);
        run_txn(8'h05, 24'h0, 8);
        run_txn(8'h04, 24'h0, 1);
        run_txn(8'h05, 24'h0, 16);
        run_txn(8'h04, 24'h0, 0);
        run_txn(8'hB9, 24'h0, 0);
        run_txn(8'h9F, 24'h0, 32);
        run_txn(8'h06, 24'h0, 0);
        run_txn(8'h03, 24'h000010, 40);
        run_txn(8'hAB, 24'h0, 0);
        run_txn(8'h9F, 24'h0, 32);
        run_txn(8'h03, 24'h123456, 12);
        run_txn(8'h9F, 24'h0, 24);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [7:0]  op;
            logic [23:0] a;
            int unsigned nb;
            int unsigned k;
            k = $urandom_range(0, 9);
            case (k)
                0:       op = 8'h9F;
                1:       op = 8'h05;
                2, 3, 9: op = 8'h03;
                4:       op = 8'h06;
                5:       op = 8'h04;
                6:       op = 8'hB9;
                7:       op = 8'hAB;
                default: op = 8'($urandom);
            endcase
            a = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 2))
                                            : 24'($urandom);
            case (k)
                0, 1:          nb = $urandom_range(0, 40);
                2, 3, 9:       nb = $urandom_range(0, 60);
                4, 5, 6, 7:    nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
                default:       nb = $urandom_range(0, 20);
            endcase
            run_txn(op, a, nb);
        end

        // Asynchronous reset in the middle of a JEDEC data phase
        run_txn(8'hAB, 24'h0, 0);
        run_txn(8'h06, 24'h0, 0);
        cs_low();
        exp_miso.push_back(8'h00);
        for (int i = 7; i >= 0; i--) begin
            sck_bit(i == 6 || i == 5 ? 1'b0 : 1'b1);
        end
        repeat (5) @(negedge clk);
        check("miso_before_reset", 32'(bus.spi_miso), 32'd1);
        check("wel_before_reset", 32'(wel), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("miso_in_reset", 32'(bus.spi_miso), 32'd0);
        check("wel_in_reset", 32'(wel), 32'd0);
        wel_m = 1'b0;
        pd_m  = 1'b0;
        exp_flags.push_back(2'b00);
        @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);

        run_txn(8'h9F, 24'h0, 32);

        repeat (20) @(negedge clk);
        check("miso_queue_left", 32'(exp_miso.size()), 32'd0);
        check("addr_queue_left", 32'(exp_addr.size()), 32'd0);
        check("flag_queue_left", 32'(exp_flags.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
